// File: rtl/veerwolf_uart_arb_pkg.sv
// Shared types and helpers for the VeeRwolf UART TX arbiter.
// Holds the arbiter state encoding and the counter-width derivation.
package veerwolf_uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_GUARD
  } arb_state_e;

  // Smallest width able to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) > max_val) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/veerwolf_uart_idle_det.sv
// Per-source idle detector: counts consecutive high bit-times on a UART line,
// saturating at IDLE_BITS; idle is asserted once the count is saturated.
module veerwolf_uart_idle_det
  import veerwolf_uart_arb_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_line,
  input  logic i_tick,
  output logic o_idle
);

  localparam int CW = cnt_width(IDLE_BITS);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_BITS);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any low sample restarts the count, so a frame in flight is never idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_line) begin
      cnt_d = '0;
    end else if (i_tick && (cnt_q != IDLE_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_idle = (cnt_q == IDLE_MAX);

endmodule

// File: rtl/veerwolf_uart_tx_arb.sv
// Glitch-free arbiter between the CPU and LiteDRAM UART TX lines: switches
// only between frames (or after a timeout) and inserts a mark guard period.
module veerwolf_uart_tx_arb
  import veerwolf_uart_arb_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int IDLE_BITS    = 11,
  parameter int GUARD_BITS   = 2,
  parameter int TIMEOUT_BITS = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_sel,
  input  logic i_tx0,
  input  logic i_tx1,
  output logic o_uart_tx,
  output logic o_sel_active,
  output logic o_switching,
  output logic o_forced
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int DW  = cnt_width(DIV - 1);
  localparam int WW  = cnt_width(TIMEOUT_BITS);
  localparam int GW  = cnt_width(GUARD_BITS);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_BITS - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_BITS);

  logic          sel_meta_q;
  logic          sel_s_q;
  logic [DW-1:0] div_q;
  logic          tick;
  logic          idle0;
  logic          idle1;

  arb_state_e    state_q;
  logic [WW-1:0] wait_q;
  logic [GW-1:0] guard_q;
  logic          uart_tx_q;
  logic          sel_active_q;
  logic          switching_q;
  logic          forced_q;

  logic          cur_line;
  logic          cur_idle;
  logic          tgt_idle;

  // i_sel comes from another clock domain; only sel_s_q is used downstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_meta_q <= 1'b0;
      sel_s_q    <= 1'b0;
    end else begin
      sel_meta_q <= i_sel;
      sel_s_q    <= sel_meta_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
    end
  end

  veerwolf_uart_idle_det #(.IDLE_BITS(IDLE_BITS)) u_idle0 (
    .clk    (clk),
    .rstn   (rstn),
    .i_line (i_tx0),
    .i_tick (tick),
    .o_idle (idle0)
  );

  veerwolf_uart_idle_det #(.IDLE_BITS(IDLE_BITS)) u_idle1 (
    .clk    (clk),
    .rstn   (rstn),
    .i_line (i_tx1),
    .i_tick (tick),
    .o_idle (idle1)
  );

  assign cur_line = sel_active_q ? i_tx1 : i_tx0;
  assign cur_idle = sel_active_q ? idle1 : idle0;
  assign tgt_idle = sel_active_q ? idle0 : idle1;

  // Guard runs GUARD_BITS+1 ticks so the first, partial bit-time is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      guard_q      <= '0;
      uart_tx_q    <= 1'b1;
      sel_active_q <= 1'b0;
      switching_q  <= 1'b0;
      forced_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          uart_tx_q <= cur_line;
          if (sel_s_q != sel_active_q) begin
            state_q     <= ST_DRAIN;
            wait_q      <= '0;
            switching_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          uart_tx_q <= cur_line;
          if (sel_s_q == sel_active_q) begin
            state_q     <= ST_RUN;
            switching_q <= 1'b0;
          end else if (cur_idle && tgt_idle) begin
            state_q      <= ST_GUARD;
            guard_q      <= '0;
            sel_active_q <= ~sel_active_q;
          end else if (tick) begin
            if (wait_q == WAIT_LAST) begin
              state_q      <= ST_GUARD;
              guard_q      <= '0;
              sel_active_q <= ~sel_active_q;
              forced_q     <= 1'b1;
            end else begin
              wait_q <= wait_q + WW'(1);
            end
          end
        end
        ST_GUARD: begin
          uart_tx_q <= 1'b1;
          if (tick) begin
            if (guard_q == GUARD_LAST) begin
              state_q     <= ST_RUN;
              switching_q <= 1'b0;
            end else begin
              guard_q <= guard_q + GW'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_RUN;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart_tx    = uart_tx_q;
  assign o_sel_active = sel_active_q;
  assign o_switching  = switching_q;
  assign o_forced     = forced_q;

endmodule

// File: tb/tb_veerwolf_uart_tx_arb.sv
// Directed bench for veerwolf_uart_tx_arb at DIV=10, IDLE_BITS=11,
// GUARD_BITS=2, TIMEOUT_BITS=64.
module tb_veerwolf_uart_tx_arb;

  localparam int CLK_FREQ_HZ  = 1_000_000;
  localparam int BAUD_RATE    = 100_000;
  localparam int IDLE_BITS    = 11;
  localparam int GUARD_BITS   = 2;
  localparam int TIMEOUT_BITS = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic i_sel = 1'b0;
  logic i_tx0 = 1'b1;
  logic i_tx1 = 1'b1;
  logic o_uart_tx;
  logic o_sel_active;
  logic o_switching;
  logic o_forced;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pat;
  logic [9:0] frame;

  always #5 clk = ~clk;

  veerwolf_uart_tx_arb #(
    .CLK_FREQ_HZ  (CLK_FREQ_HZ),
    .BAUD_RATE    (BAUD_RATE),
    .IDLE_BITS    (IDLE_BITS),
    .GUARD_BITS   (GUARD_BITS),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_sel        (i_sel),
    .i_tx0        (i_tx0),
    .i_tx1        (i_tx1),
    .o_uart_tx    (o_uart_tx),
    .o_sel_active (o_sel_active),
    .o_switching  (o_switching),
    .o_forced     (o_forced)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic sel);
    rstn  = 1'b0;
    i_sel = sel;
    i_tx0 = 1'b1;
    i_tx1 = 1'b1;
    #1;
    check("rst_tx",         int'(o_uart_tx),    1);
    check("rst_sel_active", int'(o_sel_active), 0);
    check("rst_switching",  int'(o_switching),  0);
    check("rst_forced",     int'(o_forced),     0);
    tick_n(2);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_tx",         int'(o_uart_tx),    1);
    check("post_rst_sel_active", int'(o_sel_active), 0);
    check("post_rst_switching",  int'(o_switching),  0);
  endtask

  initial begin
    int  dev, gcnt, lat, t_sw, t_g, t_done, t_back;
    logic found, early, sw_mid, forced_at_sw, forced_at_g, cur;

    #2;
    // Reset state and CPU pass-through with 1-clk latency.
    do_reset(1'b0);
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      i_tx0 = pat[i];
      i_tx1 = ~pat[i];
      @(negedge clk);
      check("run0_track", int'(o_uart_tx), int'(pat[i]));
    end

    // Clean switch with both sources idle.
    do_reset(1'b0);
    tick_n(120);
    i_sel = 1'b1;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_switching) begin
        found = 1'b1;
        lat   = i + 1;
        break;
      end
    end
    check("drain_enter", int'(found), 1);
    check("drain_lat_le3", int'(lat <= 3), 1);
    @(negedge clk);
    check("guard_sel_active", int'(o_sel_active), 1);
    check("guard_switching",  int'(o_switching),  1);
    i_tx1 = 1'b0;
    gcnt  = 1;
    dev   = (o_uart_tx !== 1'b1) ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!o_switching) break;
      gcnt++;
      if (o_uart_tx !== 1'b1) dev++;
    end
    check("guard_mark", dev, 0);
    check("guard_len_20_30", int'(gcnt >= 20 && gcnt <= 30), 1);
    for (int i = 0; i < 8; i++) begin
      i_tx1 = pat[i];
      i_tx0 = ~pat[i];
      @(negedge clk);
      check("run1_track", int'(o_uart_tx), int'(pat[i]));
    end

    // Frame 0x55 in flight on tx0 when the request arrives at bit 3.
    do_reset(1'b0);
    tick_n(120);
    frame  = {1'b1, 8'h55, 1'b0};
    dev    = 0;
    early  = 1'b0;
    sw_mid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 10; k++) begin
        i_tx0 = frame[b];
        if (b == 3 && k == 0) i_sel = 1'b1;
        @(negedge clk);
        if (o_uart_tx !== frame[b]) dev++;
        if (o_sel_active) early = 1'b1;
        if (b == 6 && k == 0) sw_mid = o_switching;
      end
    end
    t_g    = -1;
    t_done = -1;
    for (int t = 10; t < 300; t++) begin
      i_tx0 = 1'b1;
      @(negedge clk);
      if (o_uart_tx !== 1'b1) dev++;
      if (o_sel_active && t_g < 0) t_g = t;
      if (t_g >= 0 && !o_switching && t_done < 0) t_done = t;
    end
    check("frame_unmodified", dev, 0);
    check("frame_no_early_flip", int'(early), 0);
    check("frame_draining", int'(sw_mid), 1);
    check("frame_flip_after_idle", int'(t_g >= 100), 1);
    check("frame_switch_done", int'(t_done >= 110), 1);

    // Continuous traffic on tx0: timeout forces the switch.
    do_reset(1'b0);
    i_sel = 1'b1;
    t_sw  = -1;
    t_g   = -1;
    forced_at_sw = 1'b1;
    forced_at_g  = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      i_tx0 = ((c / 10) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (o_switching && t_sw < 0) begin
        t_sw = c;
        forced_at_sw = o_forced;
      end
      if (o_sel_active && t_g < 0) begin
        t_g = c;
        forced_at_g = o_forced;
      end
    end
    check("to_drain_seen", int'(t_sw >= 0), 1);
    check("to_forced_pre", int'(forced_at_sw), 0);
    check("to_window_630_650", int'(t_g >= 0 && (t_g - t_sw) >= 630 && (t_g - t_sw) <= 650), 1);
    check("to_forced_at_guard", int'(forced_at_g), 1);
    check("to_forced_sticky", int'(o_forced), 1);
    check("to_sel_active", int'(o_sel_active), 1);
    check("to_switch_done", int'(o_switching), 0);

    // Request withdrawn during DRAIN: back to RUN, no glitch on tx0 path.
    do_reset(1'b0);
    i_sel  = 1'b1;
    dev    = 0;
    early  = 1'b0;
    t_sw   = -1;
    t_back = -1;
    for (int c = 0; c < 200; c++) begin
      i_tx0 = ((c / 10) % 2 == 0) ? 1'b0 : 1'b1;
      cur   = i_tx0;
      @(negedge clk);
      if (o_uart_tx !== cur) dev++;
      if (o_sel_active) early = 1'b1;
      if (o_switching && t_sw < 0) begin
        t_sw  = c;
        i_sel = 1'b0;
      end
      if (t_sw >= 0 && !o_switching && t_back < 0) t_back = c;
    end
    check("abort_drain_seen", int'(t_sw >= 0), 1);
    check("abort_back_to_run", int'(t_back >= 0 && (t_back - t_sw) <= 5), 1);
    check("abort_sel_active", int'(early), 0);
    check("abort_no_glitch", dev, 0);
    check("abort_switching_end", int'(o_switching), 0);

    // Reset pulsed during GUARD, request held: a fresh switch completes.
    do_reset(1'b0);
    tick_n(120);
    i_sel = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_sel_active && o_switching) begin
        found = 1'b1;
        break;
      end
    end
    check("rg_guard_reached", int'(found), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("rg_tx_mark",    int'(o_uart_tx),    1);
    check("rg_sel_active", int'(o_sel_active), 0);
    check("rg_switching",  int'(o_switching),  0);
    @(negedge clk);
    rstn = 1'b1;
    t_sw   = -1;
    t_done = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_switching && t_sw < 0) t_sw = c;
      if (t_sw >= 0 && o_sel_active && !o_switching) begin
        t_done = c;
        break;
      end
    end
    check("rg_redrain_prompt", int'(t_sw >= 0 && t_sw <= 4), 1);
    check("rg_switch_done", int'(t_done >= 0), 1);
    check("rg_not_forced", int'(o_forced), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
